// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the decode-to-execute bundle.
// Used by y86_regfile and decode_stage.
package y86_pkg;

  localparam int DATA_W = 64;
  localparam int NREGS  = 15;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  typedef struct packed {
    logic [3:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] valC;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
  } id_ex_t;

  localparam id_ex_t EX_BUBBLE = '{
    stat:  S_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    valC:  '0,
    valA:  '0,
    valB:  '0,
    dstE:  RNONE,
    dstM:  RNONE,
    srcA:  RNONE,
    srcB:  RNONE
  };

endpackage

// File: rtl/y86_regfile.sv
// 15x64 register file: combinational reads (ID F reads 0),
// two write ports, M port wins on collision. Optional DECODE_DEBUG_PORT_EN.
module y86_regfile
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef DECODE_DEBUG_PORT_EN
  input  logic [3:0]        dbg_raddr_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
`endif
  input  logic [3:0]        raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [3:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [3:0]        waddr_e_i,
  input  logic [DATA_W-1:0] wdata_e_i,
  input  logic [3:0]        waddr_m_i,
  input  logic [DATA_W-1:0] wdata_m_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  assign rdata_a_o =
    (raddr_a_i == RNONE) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o =
    (raddr_b_i == RNONE) ? '0 : regs_q[raddr_b_i];

`ifdef DECODE_DEBUG_PORT_EN
  assign dbg_rdata_o =
    (dbg_raddr_i == RNONE) ? '0 : regs_q[dbg_raddr_i];
`endif

  // Clear on reset; else commit E then M so M wins a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (waddr_e_i != RNONE) begin
        regs_q[waddr_e_i] <= wdata_e_i;
      end
      if (waddr_m_i != RNONE) begin
        regs_q[waddr_m_i] <= wdata_m_i;
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode/writeback: register IDs, forwarding, E register.
// DECODE_DEBUG_PORT_EN adds dbg_raddr/dbg_rdata regfile peek.
module decode_stage
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef DECODE_DEBUG_PORT_EN
  input  logic [3:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
`endif
  input  logic [3:0]        D_stat,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic              E_bubble,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB
);

  logic [3:0]        src_a, src_b;
  logic [3:0]        dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b;
  id_ex_t            e_d, e_q;

  y86_regfile u_rf (
    .clk       (clk),
    .rst       (rst),
`ifdef DECODE_DEBUG_PORT_EN
    .dbg_raddr_i (dbg_raddr),
    .dbg_rdata_o (dbg_rdata),
`endif
    .raddr_a_i (src_a),
    .rdata_a_o (rf_a),
    .raddr_b_i (src_b),
    .rdata_b_o (rf_b),
    .waddr_e_i (W_dstE),
    .wdata_e_i (W_valE),
    .waddr_m_i (W_dstM),
    .wdata_m_i (W_valM)
  );

  // Newest producer first; ID F never forwards.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [3:0]        src,
    input logic [DATA_W-1:0] rf
  );
    if (src == RNONE)       return rf;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf;
  endfunction

  // Source and destination register IDs per icode.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    unique case (D_icode)
      I_RRMOVQ: begin
        src_a = D_rA;
        dst_e = D_rB;
      end
      I_IRMOVQ: dst_e = D_rB;
      I_RMMOVQ: begin
        src_a = D_rA;
        src_b = D_rB;
      end
      I_MRMOVQ: begin
        src_b = D_rB;
        dst_m = D_rA;
      end
      I_OPQ: begin
        src_a = D_rA;
        src_b = D_rB;
        dst_e = D_rB;
      end
      I_CALL: begin
        src_b = RRSP;
        dst_e = RRSP;
      end
      I_RET: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
      end
      I_PUSHQ: begin
        src_a = D_rA;
        src_b = RRSP;
        dst_e = RRSP;
      end
      I_POPQ: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
        dst_m = D_rA;
      end
      default: ;
    endcase
  end

  // Next E contents; jumps and calls carry valP in valA.
  always_comb begin
    e_d       = EX_BUBBLE;
    e_d.stat  = D_stat;
    e_d.icode = D_icode;
    e_d.ifun  = D_ifun;
    e_d.valC  = D_valC;
    e_d.valA  = (D_icode == I_JXX || D_icode == I_CALL)
                ? D_valP : fwd(src_a, rf_a);
    e_d.valB  = fwd(src_b, rf_b);
    e_d.dstE  = dst_e;
    e_d.dstM  = dst_m;
    e_d.srcA  = src_a;
    e_d.srcB  = src_b;
  end

  // E register; reset and bubble both load the nop bundle.
  always_ff @(posedge clk) begin
    if (rst || E_bubble) begin
      e_q <= EX_BUBBLE;
    end else begin
      e_q <= e_d;
    end
  end

  assign d_srcA  = src_a;
  assign d_srcB  = src_b;
  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.valC;
  assign E_valA  = e_q.valA;
  assign E_valB  = e_q.valB;
  assign E_dstE  = e_q.dstE;
  assign E_dstM  = e_q.dstM;
  assign E_srcA  = e_q.srcA;
  assign E_srcB  = e_q.srcB;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected E bundles are
// queued at drive time and popped one cycle later.
module tb_decode_stage;
  import y86_pkg::*;

  logic        clk, rst;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_stat, E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
`ifdef DECODE_DEBUG_PORT_EN
  logic [3:0]  dbg_raddr;
  logic [63:0] dbg_rdata;
`endif

  id_ex_t sb[$];
  int ntests = 0;
  int nfail = 0;

  decode_stage dut (
    .clk(clk), .rst(rst),
`ifdef DECODE_DEBUG_PORT_EN
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
`endif
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic id_ex_t mk(
    input logic [3:0] stat, icode, ifun,
    input logic [63:0] valc, vala, valb,
    input logic [3:0] dste, dstm, srca, srcb
  );
    id_ex_t r;
    r.stat = stat; r.icode = icode; r.ifun = ifun;
    r.valC = valc; r.valA = vala; r.valB = valb;
    r.dstE = dste; r.dstM = dstm;
    r.srcA = srca; r.srcB = srcb;
    return r;
  endfunction

  function automatic id_ex_t cur_e();
    id_ex_t r;
    r.stat = E_stat; r.icode = E_icode; r.ifun = E_ifun;
    r.valC = E_valC; r.valA = E_valA; r.valB = E_valB;
    r.dstE = E_dstE; r.dstM = E_dstM;
    r.srcA = E_srcA; r.srcB = E_srcB;
    return r;
  endfunction

  task automatic set_d(
    input logic [3:0] stat, icode, ifun, ra, rb,
    input logic [63:0] valc, valp
  );
    D_stat = stat; D_icode = icode; D_ifun = ifun;
    D_rA = ra; D_rB = rb; D_valC = valc; D_valP = valp;
  endtask

  task automatic idle_fwd();
    e_dstE = 4'hF; e_valE = '0;
    M_dstE = 4'hF; M_valE = '0;
    M_dstM = 4'hF; m_valM = '0;
    W_dstE = 4'hF; W_valE = '0;
    W_dstM = 4'hF; W_valM = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    id_ex_t got, exp;
    rst = 1'b1;
    set_d(4'h1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h33, 64'h0);
    W_dstE = 4'h2; W_valE = 64'hBB;
    sb.push_back(EX_BUBBLE);
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL reset_e: got %h want %h", got, exp);
    end
    rst = 1'b0;
    idle_fwd();
    set_d(4'h1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
    sb.push_back(mk(4'h1, 4'h6, 4'h0, 64'h0, 64'h0, 64'h0,
                    4'h3, 4'hF, 4'h2, 4'h3));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL reset_rf: got %h want %h", got, exp);
    end
  endtask

  task automatic test_wb_read();
    id_ex_t got, exp;
    idle_fwd();
    W_dstE = 4'h3; W_valE = 64'h55;
    set_d(4'h1, 4'h2, 4'h0, 4'h3, 4'h5, 64'h0, 64'h10);
    sb.push_back(mk(4'h1, 4'h2, 4'h0, 64'h0, 64'h55, 64'h0,
                    4'h5, 4'hF, 4'h3, 4'hF));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL wb_fwd: got %h want %h", got, exp);
    end
    idle_fwd();
    set_d(4'h1, 4'h2, 4'h0, 4'h3, 4'h5, 64'h0, 64'h12);
    sb.push_back(mk(4'h1, 4'h2, 4'h0, 64'h0, 64'h55, 64'h0,
                    4'h5, 4'hF, 4'h3, 4'hF));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL wb_commit: got %h want %h", got, exp);
    end
  endtask

  task automatic test_fwd_priority();
    id_ex_t got, exp;
    idle_fwd();
    set_d(4'h1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
    e_dstE = 4'h2; e_valE = 64'd10;
    M_dstE = 4'h2; M_valE = 64'd20;
    W_dstE = 4'h3; W_valE = 64'd7;
    sb.push_back(mk(4'h1, 4'h6, 4'h0, 64'h0, 64'd10, 64'd7,
                    4'h3, 4'hF, 4'h2, 4'h3));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL fwd_e: got %h want %h", got, exp);
    end
    idle_fwd();
    set_d(4'h1, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h0);
    M_dstM = 4'h2; m_valM = 64'd30;
    M_dstE = 4'h2; M_valE = 64'd20;
    W_dstE = 4'h3; W_valE = 64'd9;
    W_dstM = 4'h3; W_valM = 64'd8;
    sb.push_back(mk(4'h1, 4'h6, 4'h1, 64'h0, 64'd30, 64'd8,
                    4'h3, 4'hF, 4'h2, 4'h3));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL fwd_m: got %h want %h", got, exp);
    end
    idle_fwd();
    M_dstE = 4'h2; M_valE = 64'd20;
    W_dstM = 4'h2; W_valM = 64'd40;
    sb.push_back(mk(4'h1, 4'h6, 4'h1, 64'h0, 64'd20, 64'd8,
                    4'h3, 4'hF, 4'h2, 4'h3));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL fwd_me: got %h want %h", got, exp);
    end
    idle_fwd();
    W_dstE = 4'h2; W_valE = 64'd50;
    sb.push_back(mk(4'h1, 4'h6, 4'h1, 64'h0, 64'd50, 64'd8,
                    4'h3, 4'hF, 4'h2, 4'h3));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL fwd_we: got %h want %h", got, exp);
    end
    idle_fwd();
    e_valE = 64'd99; M_valE = 64'd98; m_valM = 64'd97;
    W_valE = 64'd96; W_valM = 64'd95;
    set_d(4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    sb.push_back(mk(4'h1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0,
                    4'hF, 4'hF, 4'hF, 4'hF));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL no_fwd_rnone: got %h want %h", got, exp);
    end
  endtask

  task automatic test_call();
    id_ex_t got, exp;
    idle_fwd();
    W_dstE = 4'h4; W_valE = 64'h100;
    set_d(4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    sb.push_back(mk(4'h1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0,
                    4'hF, 4'hF, 4'hF, 4'hF));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL rsp_wr: got %h want %h", got, exp);
    end
    idle_fwd();
    set_d(4'h1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h40);
    sb.push_back(mk(4'h1, 4'h8, 4'h0, 64'h200, 64'h40, 64'h100,
                    4'h4, 4'hF, 4'hF, 4'h4));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL call: got %h want %h", got, exp);
    end
    set_d(4'h1, 4'h7, 4'h3, 4'hF, 4'hF, 64'h300, 64'h77);
    sb.push_back(mk(4'h1, 4'h7, 4'h3, 64'h300, 64'h77, 64'h0,
                    4'hF, 4'hF, 4'hF, 4'hF));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL jxx: got %h want %h", got, exp);
    end
  endtask

  task automatic test_popq_bubble();
    id_ex_t got, exp;
    idle_fwd();
    W_dstE = 4'h9; W_valE = 64'h99;
    set_d(4'h1, 4'hB, 4'h0, 4'h6, 4'hF, 64'h0, 64'h0);
    E_bubble = 1'b1;
    sb.push_back(EX_BUBBLE);
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL popq_bubble: got %h want %h", got, exp);
    end
    E_bubble = 1'b0;
    idle_fwd();
    sb.push_back(mk(4'h1, 4'hB, 4'h0, 64'h0, 64'h100, 64'h100,
                    4'h4, 4'h6, 4'h4, 4'h4));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL popq: got %h want %h", got, exp);
    end
    set_d(4'h1, 4'hA, 4'h0, 4'h9, 4'hF, 64'h0, 64'h0);
    sb.push_back(mk(4'h1, 4'hA, 4'h0, 64'h0, 64'h99, 64'h100,
                    4'h4, 4'hF, 4'h9, 4'h4));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL pushq_bubble_wb: got %h want %h", got, exp);
    end
  endtask

  task automatic test_dual_write();
    id_ex_t got, exp;
    idle_fwd();
    W_dstE = 4'h7; W_valE = 64'd1;
    W_dstM = 4'h7; W_valM = 64'd2;
    set_d(4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    sb.push_back(mk(4'h1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0,
                    4'hF, 4'hF, 4'hF, 4'hF));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL dual_wr_nop: got %h want %h", got, exp);
    end
    idle_fwd();
    set_d(4'h1, 4'h2, 4'h0, 4'h7, 4'h1, 64'h0, 64'h0);
    sb.push_back(mk(4'h1, 4'h2, 4'h0, 64'h0, 64'd2, 64'h0,
                    4'h1, 4'hF, 4'h7, 4'hF));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL dual_write: got %h want %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    id_ex_t got, exp;
    idle_fwd();
    for (int i = 0; i < 4; i++) begin
      set_d(4'h1, 4'h5, 4'h0, 4'(i), 4'h4,
            64'(i * 8), 64'h0);
      sb.push_back(mk(4'h1, 4'h5, 4'h0, 64'(i * 8), 64'h0,
                      64'h100, 4'hF, 4'(i), 4'hF, 4'h4));
      step();
      got = cur_e(); exp = sb.pop_front(); ntests++;
      if (got !== exp) begin
        nfail++;
        $display("FAIL b2b_mrmovq%0d: got %h want %h",
                 i, got, exp);
      end
    end
  endtask

  task automatic test_stat_pass();
    id_ex_t got, exp;
    idle_fwd();
    set_d(4'h2, 4'h0, 4'h0, 4'h3, 4'h3, 64'h0, 64'h0);
    sb.push_back(mk(4'h2, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0,
                    4'hF, 4'hF, 4'hF, 4'hF));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL halt_pass: got %h want %h", got, exp);
    end
    set_d(4'h4, 4'hC, 4'h5, 4'h1, 4'h2, 64'h5A, 64'h0);
    sb.push_back(mk(4'h4, 4'hC, 4'h5, 64'h5A, 64'h0, 64'h0,
                    4'hF, 4'hF, 4'hF, 4'hF));
    step();
    got = cur_e(); exp = sb.pop_front(); ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL ins_pass: got %h want %h", got, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    E_bubble = 1'b0;
`ifdef DECODE_DEBUG_PORT_EN
    dbg_raddr = 4'hF;
`endif
    idle_fwd();
    set_d(4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    test_reset();
    test_wb_read();
    test_fwd_priority();
    test_call();
    test_popq_bubble();
    test_dual_write();
    test_back_to_back();
    test_stat_pass();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
